// File: rtl/div32_if.sv
// rtl/div32_if.sv - request/response bundle for the div32 sequential divider
interface div32_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, a, b,
    input  busy, done, result
  );

  modport slave (
    input  start, a, b,
    output busy, done, result
  );
endinterface

// File: rtl/div32.sv
// rtl/div32.sv - restoring radix-2 divider, WIDTH iterations, optional signed mode via DIV32_SIGNED_EN
module div32 #(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  div32_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [CW-1:0]      cnt;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] result_q;

  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic [WIDTH-1:0]   a_cap;
  logic [WIDTH-1:0]   b_cap;
  logic [WIDTH-1:0]   q_fin;
  logic [WIDTH-1:0]   r_fin;

`ifdef DIV32_SIGNED_EN
  // Signs remembered from capture; operands run through the core as magnitudes.
  logic neg_q;
  logic neg_r;

  // Magnitudes at capture, sign fix-up on the final iteration's values.
  always_comb begin
    a_cap = bus.a[WIDTH-1] ? -bus.a : bus.a;
    b_cap = bus.b[WIDTH-1] ? -bus.b : bus.b;
    q_fin = neg_q ? -quo_nx : quo_nx;
    r_fin = neg_r ? -rem_nx : rem_nx;
  end
`else
  // Unsigned: operands and results pass straight through.
  always_comb begin
    a_cap = bus.a;
    b_cap = bus.b;
    q_fin = quo_nx;
    r_fin = rem_nx;
  end
`endif

  // One restoring step: shift {rem,quo}, trial-subtract the divisor at WIDTH+1 bits.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    ge     = ~diff[WIDTH];
    rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_nx = {quo[WIDTH-2:0], ge};
  end

  // Control FSM with registered busy/done/result; reset aborts any division.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef DIV32_SIGNED_EN
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state  <= RUN;
            dvs    <= b_cap;
            rem    <= '0;
            quo    <= a_cap;
            cnt    <= '0;
            busy_q <= 1'b1;
`ifdef DIV32_SIGNED_EN
            neg_q  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            neg_r  <= bus.a[WIDTH-1];
`endif
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= {r_fin, q_fin};
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: doc/div32.md
DIV32 -- requirements
Module: div32

Interface
REQ-001: Parameter WIDTH, default 32, operand width; the result is 2*WIDTH bits; only 32 is required to be supported.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: rst  input  1  reset; synchronous, active-high.
REQ-004: start  input  1  request pulse; sampled only in IDLE.
REQ-005: a  input  32  dividend; captured on the accepted start edge.
REQ-006: b  input  32  divisor; captured on the accepted start edge.
REQ-007: busy  output  1  high while iterating (RUN).
REQ-008: done  output  1  one-cycle completion strobe.
REQ-009: result  output  64  {remainder[63:32], quotient[31:0]}.

Function
REQ-010: FSM states SHALL be IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE after the 32nd iteration.
- DONE->IDLE unconditionally after one cycle.
REQ-011: Accepted start at edge N SHALL latch a and b, clear the partial remainder, load the quotient register with a, and clear the iteration counter.
REQ-012: Each RUN edge SHALL perform one restoring step:
- shift {rem,quo} left by 1;
- trial subtract rem-b at 33-bit width;
- if non-negative, rem=difference and quo[0]=1, else rem unchanged and quo[0]=0.
REQ-013: Iterations SHALL occur at edges N+1..N+32; result SHALL be registered at edge N+32; done SHALL be high only in the cycle following edge N+32.
REQ-014: busy SHALL be high from edge N+1 through edge N+32 and SHALL be low in IDLE and DONE.
REQ-015: result SHALL hold its last value until the next completion or reset; it SHALL NOT change during RUN.
REQ-016: start SHALL be ignored in RUN and DONE; a and b changes after capture SHALL have no effect.
REQ-017: Unsigned divide-by-zero SHALL produce quotient 0xFFFFFFFF and remainder = a, with normal 33-cycle latency and no error flag.
REQ-018: Edge cases.
- a<b SHALL give quotient 0 and remainder a.
- a=0 SHALL give quotient 0 and remainder 0.

Reset
REQ-019: rst=1 at any edge SHALL force IDLE, busy=0, done=0, result=0, and clear counter and working registers.
REQ-020: rst SHALL have priority over start and SHALL abort an in-progress division without producing done.
REQ-021: The first start accepted after reset deassertion SHALL behave per REQ-011..REQ-013.

Configuration
REQ-022: Macro DIV32_SIGNED_EN SHALL select the division mode; ports and latency SHALL be identical in both builds.
REQ-023: With DIV32_SIGNED_EN defined, the block SHALL use two's-complement division.
- a and b SHALL be treated as two's complement.
- Magnitudes SHALL be taken at capture; sign fix-up SHALL be applied at edge N+32.
- Quotient SHALL truncate toward zero; remainder SHALL carry the sign of a.
REQ-024: With DIV32_SIGNED_EN defined, the boundary values SHALL be:
- divide-by-zero: quotient -1 if a>=0, +1 if a<0; remainder = a.
- 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
REQ-025: Without DIV32_SIGNED_EN, all operands SHALL be unsigned and no sign logic SHALL be synthesized.

Verification
REQ-026: a=100, b=7, start at edge N -> done high only after edge N+32; result=0x00000002_0000000E; busy high 32 cycles.
REQ-027: a=5, b=0 (unsigned build) -> result=0x00000005_FFFFFFFF after 33 cycles.
REQ-028: a=0xFFFFFFFF, b=1; then a=3, b=10 -> results 0x00000000_FFFFFFFF, then 0x00000003_00000000.
REQ-029: Start 1000/3, assert rst at iteration 10 -> next cycle busy=0, done=0, result=0, done never pulses; a new 1000/3 then gives 0x00000001_0000014D.
REQ-030: Start pulses repeated every cycle during RUN and DONE with different a/b -> ignored; only the first operation completes; the next start is accepted only from IDLE.
REQ-031: a=0xFFFFFFF9, b=2 -> the two builds give:
- signed build: 0xFFFFFFFF_FFFFFFFD.
- unsigned build: 0x00000001_7FFFFFFC.
